// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory port between an instruction-fetch (IF) port and a
// data (DM) port. One transaction is outstanding at most: IDLE (grant) -> ADDR
// (bus_req until bus_ready) -> RESP (wait bus_rvalid) -> IDLE.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   if_req, if_addr                fetch request (held until if_gnt) and address
//   flush_if                       discard the in-flight fetch result
//   if_gnt, if_rvalid, if_rdata    fetch grant pulse, data-valid pulse, data
//   dm_req, dm_we, dm_addr,
//   dm_wdata, dm_wstrb             data request (held until dm_gnt) and fields
//   dm_gnt, dm_rvalid, dm_rdata    data grant pulse, read-data/write-ack pulse, data
//   bus_req, bus_we, bus_addr,
//   bus_wdata, bus_wstrb           shared port address phase
//   bus_ready                      address phase accepted
//   bus_rvalid, bus_rdata          response phase
//   busy                           high whenever not IDLE
module bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        flush_if,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_wstrb,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StAddr, StResp} state_e;

  state_e      state_q, state_d;
  logic        owner_if_q, owner_if_d;  // 0: DM owns the bus, 1: IF owns it
  logic [1:0]  starve_q, starve_d;
  logic        drop_q, drop_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic if_wins, dm_wins;

  // DM has priority unless IF has lost three consecutive contended rounds.
  assign if_wins = if_req && (!dm_req || (starve_q == 2'd3));
  assign dm_wins = dm_req && !if_wins;

  always_comb begin
    state_d    = state_q;
    owner_if_d = owner_if_q;
    starve_d   = starve_q;
    drop_d     = drop_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    if_gnt     = 1'b0;
    dm_gnt     = 1'b0;
    if_rvalid  = 1'b0;
    dm_rvalid  = 1'b0;

    unique case (state_q)
      StIdle: begin
        drop_d = 1'b0;
        if (if_wins) begin
          if_gnt     = 1'b1;
          owner_if_d = 1'b1;
          starve_d   = 2'd0;
          drop_d     = flush_if;
          we_d       = 1'b0;
          addr_d     = if_addr;
          wdata_d    = 32'd0;
          wstrb_d    = 4'd0;
          state_d    = StAddr;
        end else if (dm_wins) begin
          dm_gnt     = 1'b1;
          owner_if_d = 1'b0;
          starve_d   = if_req ? starve_q + 2'd1 : 2'd0;
          we_d       = dm_we;
          addr_d     = dm_addr;
          wdata_d    = dm_wdata;
          wstrb_d    = dm_wstrb;
          state_d    = StAddr;
        end
      end
      StAddr: begin
        if (owner_if_q && flush_if) drop_d = 1'b1;
        if (bus_ready) state_d = StResp;
      end
      StResp: begin
        if (owner_if_q && flush_if) drop_d = 1'b1;
        if (bus_rvalid) begin
          // A flush arriving on the response cycle itself also discards the data.
          if_rvalid = owner_if_q && !drop_q && !flush_if;
          dm_rvalid = !owner_if_q;
          drop_d    = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Reset outranks everything, including same-cycle grants and responses.
    if (rst) begin
      if_gnt    = 1'b0;
      dm_gnt    = 1'b0;
      if_rvalid = 1'b0;
      dm_rvalid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_if_q <= 1'b0;
      starve_q   <= 2'd0;
      drop_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
    end else begin
      state_q    <= state_d;
      owner_if_q <= owner_if_d;
      starve_q   <= starve_d;
      drop_q     <= drop_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
    end
  end

  assign bus_req   = (state_q == StAddr);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_wstrb = wstrb_q;
  assign if_rdata  = bus_rdata;
  assign dm_rdata  = bus_rdata;
  assign busy      = (state_q != StIdle);

endmodule
